// File: rtl/barcode_pkg.sv
// Shared constants, barcode table and FSM state encoding for the product barcode emitter.
// No ports; imported by the interface, ROM and emitter.
package barcode_pkg;

  localparam int unsigned NUM_PRODUCTS = 12;
  localparam int unsigned NUM_DIGITS   = 4;
  localparam logic [3:0]  INVALID_ID   = 4'hF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StDone  = 2'd2,
    StError = 2'd3
  } state_e;

  // Digits packed MSB-first: nibble [15:12] is digit_index 0 (first scanned).
  function automatic logic [15:0] barcode_word(input logic [3:0] id);
    case (id)
      4'd0:    return 16'h3124;
      4'd1:    return 16'h4132;
      4'd2:    return 16'h4133;
      4'd3:    return 16'h3121;
      4'd4:    return 16'h3133;
      4'd5:    return 16'h3214;
      4'd6:    return 16'h2134;
      4'd7:    return 16'h2144;
      4'd8:    return 16'h3112;
      4'd9:    return 16'h4321;
      4'd10:   return 16'h1342;
      4'd11:   return 16'h1213;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/product_barcode_emitter_if.sv
// Request / digit-stream bundle between a requester-consumer (master) and the emitter (slave).
// Signals: req, product_id, digit_ready (master -> slave);
//          busy, digit, digit_index, digit_valid, done, error (slave -> master).
interface product_barcode_emitter_if;
  logic       req;
  logic [3:0] product_id;
  logic       busy;
  logic [3:0] digit;
  logic [1:0] digit_index;
  logic       digit_valid;
  logic       digit_ready;
  logic       done;
  logic       error;

  modport master (
    output req, product_id, digit_ready,
    input  busy, digit, digit_index, digit_valid, done, error
  );

  modport slave (
    input  req, product_id, digit_ready,
    output busy, digit, digit_index, digit_valid, done, error
  );
endinterface

// File: rtl/product_barcode_rom.sv
// Combinational barcode table lookup.
// Ports: id (product ID), index (digit position, 0 = MSB) -> digit (BCD, 0 when invalid),
//        valid (id in range and index in range).
module product_barcode_rom
  import barcode_pkg::*;
#(
  parameter int unsigned NUM_PRODUCTS = barcode_pkg::NUM_PRODUCTS,
  parameter int unsigned NUM_DIGITS   = barcode_pkg::NUM_DIGITS
) (
  input  logic [3:0] id,
  input  logic [1:0] index,
  output logic [3:0] digit,
  output logic       valid
);

  logic [15:0] word;
  logic [3:0]  nibble;

  assign valid = (32'(id) < NUM_PRODUCTS) && (32'(index) < NUM_DIGITS);
  assign word  = barcode_word(id);

  always_comb begin
    nibble = 4'd0;
    case (index)
      2'd0:    nibble = word[15:12];
      2'd1:    nibble = word[11:8];
      2'd2:    nibble = word[7:4];
      default: nibble = word[3:0];
    endcase
  end

  assign digit = valid ? nibble : 4'd0;

endmodule

// File: rtl/product_barcode_emitter.sv
// Emits the BCD barcode digits of a requested product over a valid/ready stream.
// Ports: clk, reset (async, active-high), bus (slave modport: req/product_id in,
//        digit/digit_index/digit_valid out with digit_ready back-pressure, busy/done/error status).
module product_barcode_emitter
  import barcode_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = barcode_pkg::NUM_DIGITS,
  parameter int unsigned NUM_PRODUCTS = barcode_pkg::NUM_PRODUCTS
) (
  input logic                        clk,
  input logic                        reset,
  product_barcode_emitter_if.slave   bus
);

  localparam logic [1:0] LastIndex = 2'(NUM_DIGITS - 1);

  state_e     state_q;
  logic [3:0] id_q;
  logic [1:0] index_q;
  logic [3:0] digit_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;

  logic [3:0] rom_id;
  logic [1:0] rom_index;
  logic [3:0] rom_digit;
  logic       rom_valid;

  // The ROM looks one step ahead so every output can be registered: in IDLE it sees the
  // incoming ID at index 0, in SEND it sees the latched ID at the next index.
  assign rom_id    = (state_q == StIdle) ? bus.product_id : id_q;
  assign rom_index = (state_q == StSend) ? index_q + 2'd1 : 2'd0;

  product_barcode_rom #(
    .NUM_PRODUCTS(NUM_PRODUCTS),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_rom (
    .id   (rom_id),
    .index(rom_index),
    .digit(rom_digit),
    .valid(rom_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      id_q    <= 4'd0;
      index_q <= 2'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            id_q    <= bus.product_id;
            index_q <= 2'd0;
            busy_q  <= 1'b1;
            if (rom_valid) begin
              state_q <= StSend;
              valid_q <= 1'b1;
              digit_q <= rom_digit;
            end else begin
              state_q <= StError;
              error_q <= 1'b1;
            end
          end
        end
        StSend: begin
          if (bus.digit_ready) begin
            if (index_q == LastIndex) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              digit_q <= 4'd0;
              index_q <= 2'd0;
              done_q  <= 1'b1;
            end else begin
              index_q <= index_q + 2'd1;
              digit_q <= rom_digit;
            end
          end
        end
        default: begin
          // DONE and ERROR are single-cycle status states.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.digit       = digit_q;
  assign bus.digit_index = index_q;
  assign bus.digit_valid = valid_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_product_barcode_emitter.sv
// Directed bench for product_barcode_emitter with a digit scoreboard.
module tb_product_barcode_emitter;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_cnt;
  int   err_cnt;

  logic [5:0]  sb[$];  // {digit_index, digit}
  logic [15:0] tab[16] = '{16'h3124, 16'h4132, 16'h4133, 16'h3121, 16'h3133, 16'h3214,
                           16'h2134, 16'h2144, 16'h3112, 16'h4321, 16'h1342, 16'h1213,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000};

  logic       prev_stall;
  logic [3:0] prev_digit;
  logic [1:0] prev_index;

  product_barcode_emitter_if bus ();

  product_barcode_emitter #(
    .NUM_DIGITS  (4),
    .NUM_PRODUCTS(12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive req for one cycle; returns #1 after the accepting edge.
  task automatic send_req(input int id);
    logic [15:0] w;
    w = tab[id];
    if (id < 12)
      for (int k = 0; k < 4; k++) sb.push_back({2'(k), w[15-4*k -: 4]});
    bus.req        = 1'b1;
    bus.product_id = 4'(id);
    step();
    bus.req = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_index", bus.digit_index, 0);
    if (id < 12) begin
      chk("accept_valid", bus.digit_valid, 1);
      chk("accept_digit", bus.digit, w[15:12]);
    end else begin
      chk("err_pulse", bus.error, 1);
      chk("err_no_valid", bus.digit_valid, 0);
    end
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (!(bus.done || bus.error) && n < 50) begin
      step();
      n++;
    end
    chk("end_seen", bus.done | bus.error, 1);
    chk("sb_drained", sb.size(), 0);
    step();
    chk("idle_busy", bus.busy, 0);
    chk("idle_index", bus.digit_index, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_digit"}, bus.digit, 0);
    chk({tag, "_index"}, bus.digit_index, 0);
    chk({tag, "_valid"}, bus.digit_valid, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
  endtask

  // Monitor: invariants, stall stability and scoreboard pops on each transfer.
  always @(negedge clk) begin
    logic [5:0] e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      chk("flags_exclusive",
          32'(bus.done) + 32'(bus.error) + 32'(bus.digit_valid) <= 32'd1, 1);
      if (!bus.digit_valid) chk("digit_zero", bus.digit, 0);
      if (prev_stall) begin
        chk("stall_valid", bus.digit_valid, 1);
        chk("stall_digit", bus.digit, prev_digit);
        chk("stall_index", bus.digit_index, prev_index);
      end
      if (bus.digit_valid && bus.digit_ready) begin
        e = (sb.size() > 0) ? sb.pop_front() : 6'h3F;
        chk("xfer_index", bus.digit_index, e[5:4]);
        chk("xfer_digit", bus.digit, e[3:0]);
      end
      if (bus.done) done_cnt++;
      if (bus.error) err_cnt++;
      prev_stall = bus.digit_valid && !bus.digit_ready;
      prev_digit = bus.digit;
      prev_index = bus.digit_index;
    end
  end

  initial begin
    int n;
    int d0;
    int e0;
    logic [6:0] pat;
    total = 0; bad = 0; done_cnt = 0; err_cnt = 0;
    prev_stall = 1'b0; prev_digit = 4'd0; prev_index = 2'd0;
    reset = 1'b1;
    bus.req = 1'b0;
    bus.product_id = 4'd0;
    bus.digit_ready = 1'b1;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;

    // ID 5, ready high, accepted on the first edge after reset release.
    send_req(5);
    wait_end(n);
    chk("id5_latency", n, 4);
    chk("id5_done_cnt", done_cnt, 1);

    // ID 12: error only.
    d0 = done_cnt; e0 = err_cnt;
    send_req(12);
    wait_end(n);
    chk("id12_err_cnt", err_cnt - e0, 1);
    chk("id12_done_cnt", done_cnt - d0, 0);

    // ID 9 with ready pattern 1,0,0,1,0,1,1.
    pat = 7'b1001011;  // MSB first
    send_req(9);
    for (int i = 6; i >= 0; i--) begin
      bus.digit_ready = pat[i];
      step();
    end
    bus.digit_ready = 1'b1;
    chk("id9_done", bus.done, 1);
    wait_end(n);

    // ID 0 with a late req for ID 7 while busy.
    d0 = done_cnt;
    send_req(0);
    step();
    bus.product_id = 4'd7;
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    wait_end(n);
    step();
    chk("id0_single_done", done_cnt - d0, 1);

    // Reset after the second transfer of ID 10, then ID 11.
    send_req(10);
    step();
    step();
    chk("id10_index2", bus.digit_index, 2);
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    step();
    reset = 1'b0;
    send_req(11);
    wait_end(n);

    // Sweep all IDs.
    d0 = done_cnt; e0 = err_cnt;
    for (int id = 0; id < 16; id++) begin
      send_req(id);
      wait_end(n);
    end
    chk("sweep_done", done_cnt - d0, 12);
    chk("sweep_err", err_cnt - e0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_barcode_emitter.md
PRODUCT_BARCODE_EMITTER -- requirements
Module: product_barcode_emitter

Interface
REQ-001 Parameter NUM_DIGITS, default 4, sets the number of barcode digits emitted per product.
REQ-002 Parameter NUM_PRODUCTS, default 12, sets the number of valid product IDs (0 to NUM_PRODUCTS-1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request to emit the barcode for product_id; sampled only in IDLE.
REQ-006 product_id  input  4  product to encode; captured when req is accepted.
REQ-007 busy  output  1  high from the cycle after acceptance until the DONE/ERROR cycle, inclusive.
REQ-008 digit  output  4  current barcode digit, BCD 1..9.
REQ-009 digit_index  output  2  position of the current digit; 0 is the most-significant digit (first scanned).
REQ-010 digit_valid  output  1  digit and digit_index are valid.
REQ-011 digit_ready  input  1  consumer accepts the digit; a transfer occurs when digit_valid and digit_ready are both high.
REQ-012 done  output  1  one-cycle pulse after the last digit transfers.
REQ-013 error  output  1  one-cycle pulse when the captured product_id is >= NUM_PRODUCTS; no digits are emitted.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SEND, DONE and ERROR.
REQ-015 In IDLE with req=1, the block SHALL latch product_id; next state is SEND if the ID is valid, otherwise ERROR.
REQ-016 Latency: for req accepted at rising edge N, digit_valid SHALL be 1 after edge N, carrying digit_index=0.
REQ-017 In SEND, digit_valid SHALL be 1; digit is the table entry for the latched ID at digit_index.
REQ-018 While digit_valid=1 and digit_ready=0, digit and digit_index SHALL hold stable.
REQ-019 On each transfer, digit_index SHALL increment; on the transfer of index NUM_DIGITS-1, the FSM SHALL go to DONE.
REQ-020 Index wrap-around SHALL NOT occur: after DONE, digit_index returns to 0 in IDLE.
REQ-021 digit_ready held high continuously SHALL yield one digit per cycle: four consecutive transfer cycles, then done.
REQ-022 DONE and ERROR SHALL last exactly one cycle each, asserting done or error respectively, then return to IDLE.
REQ-023 req SHALL be ignored outside IDLE; product_id changes while busy SHALL have no effect on the emitted digits.
REQ-024 A new req SHALL be accepted no earlier than the cycle after DONE/ERROR (minimum spacing of six cycles per product with ready held high).
REQ-025 digit SHALL read 0 whenever digit_valid=0.
REQ-026 done, error and digit_valid SHALL never be high in the same cycle.

Reset
REQ-027 Asserting reset at any time, including mid-SEND, SHALL abort the emission and force state IDLE.
REQ-028 Reset values: busy=0, digit=0, digit_index=0, digit_valid=0, done=0, error=0, latched ID=0.
REQ-029 The first req SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 The shared package barcode_pkg SHALL hold:
  - NUM_PRODUCTS and NUM_DIGITS
  - INVALID_ID = 4'hF
  - the product-to-barcode table (ID 0 = 3,1,2,4; 1 = 4,1,3,2; 2 = 4,1,3,3; 3 = 3,1,2,1; 4 = 3,1,3,3; 5 = 3,2,1,4; 6 = 2,1,3,4; 7 = 2,1,4,4; 8 = 3,1,1,2; 9 = 4,3,2,1; 10 = 1,3,4,2; 11 = 1,2,1,3)
  - the FSM state encoding
REQ-031 The table lookup SHALL be one combinational sub-module, product_barcode_rom (inputs: ID, index; outputs: digit, valid). The FSM lives in product_barcode_emitter.

Verification
REQ-032 ID 5, req for one cycle, ready always high -> digits 3,2,1,4 on four consecutive cycles starting at N+1, then done pulse, busy=0.
REQ-033 ID 12 -> error pulse at N+1, digit_valid never asserted, done never asserted.
REQ-034 ID 9, ready toggled 1,0,0,1,0,1,1 -> digits 4,3,2,1 with each digit held stable during every ready=0 stall.
REQ-035 ID 0 request, then product_id changed to 7 and req re-pulsed mid-SEND -> output is still 3,1,2,4, with only one done pulse.
REQ-036 Reset asserted after the second transfer of ID 10 -> all outputs 0 immediately; the next req for ID 11 emits 1,2,1,3.
REQ-037 Sweep IDs 0..15 and compare the emitted digits against the package table -> 12 done pulses and 4 error pulses.
